adc_stim_sequencer: RTL and testbench
=====================================

Name: adc_stim_sequencer

Overview:
Parametrised, clocked stimulus sequencer for ADC-forward bench and bring-up use. It drives a programmable table of (v_actual, v_signal) vector pairs into the DUT. It advances one entry per acknowledge edge from the DUT, after a programmable settle time. It supports one-shot and loop modes, abort, and table reload between runs.

Parameters:
- DATA_W, 16, width of v_actual / v_signal / table entries
- DEPTH, 4, number of table entries (≥2)
- IDX_W, $clog2(DEPTH), index width
- SETTLE_W, 8, width of settle counter / settle_cycles input
- LOOP_W, 8, width of loop counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: begin sequence at entry 0
- abort  in  1  single-cycle pulse: return to IDLE
- loop_en  in  1  1 = wrap after last entry; 0 = one-shot
- settle_cycles  in  SETTLE_W  cycles to wait after applying a vector before an ack is accepted
- status_in  in  1  DUT acknowledge level, synchronous to clk; its rising edge advances the sequence
- wr_en  in  1  table write strobe
- wr_addr  in  IDX_W  table write address
- wr_actual  in  DATA_W  table write data, actual
- wr_signal  in  DATA_W  table write data, signal
- v_actual  out  DATA_W  applied actual value
- v_signal  out  DATA_W  applied signal value
- stim_valid  out  1  vector on outputs is live
- status_out  out  IDX_W  index of applied entry
- done  out  1  one-shot sequence complete
- loop_cnt  out  LOOP_W  completed passes, saturating

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset state: FSM in IDLE; all outputs 0; table entries 0; status_in edge register 0.
- FSM states are IDLE, SETTLE, WAIT_ACK, DONE.
- Edge detect: prev_status is registered every cycle in all states. ack = status_in & ~prev_status. An ack outside WAIT_ACK is discarded and is not queued.
- Table writes:
  - Accepted only in IDLE or DONE. Ignored in other states.
  - Ignored when wr_addr ≥ DEPTH.
  - A write in the same cycle as start is visible to entry load, with write-first semantics.
- IDLE:
  - On start: index ← 0, load table[0] onto v_actual/v_signal, stim_valid ← 1, loop_cnt ← 0, go to SETTLE.
  - Outputs are valid 1 cycle after start.
- SETTLE:
  - Counter loaded with settle_cycles on every vector load.
  - Decrements each cycle; at 0, go to WAIT_ACK.
  - If settle_cycles = 0, go to WAIT_ACK on the cycle after the load.
- WAIT_ACK, on ack:
  - If index < DEPTH-1: index+1, load next entry, go to SETTLE.
  - If index = DEPTH-1 and loop_en = 1: index ← 0, loop_cnt +1 (saturating at all-ones), load entry 0, go to SETTLE.
  - If index = DEPTH-1 and loop_en = 0: go to DONE, done ← 1, stim_valid ← 0, last vector held on v_* and status_out.
- DONE: start behaves as in IDLE, clears done and restarts.
- abort in any state: next cycle IDLE; v_*, status_out, stim_valid and done cleared; loop_cnt held. abort has priority over start and ack in the same cycle.
- start outside IDLE/DONE is ignored.
- loop_en is sampled only at the last-entry ack.
- settle_cycles is sampled at each vector load.
- Reset asserted mid-sequence: all state returns immediately to reset values, including table contents.

Optional Feature:
- Macro ADC_STIM_CHECK_EN.
- With the macro:
  - Adds ports dut_result (in, DATA_W), err_cnt (out, 16, saturating) and err_flag (out, 1, sticky).
  - Each table entry gains an expected field, written via an added wr_expect (in, DATA_W).
  - On each accepted ack, dut_result is compared with the current entry's expected value; a mismatch increments err_cnt and sets err_flag.
  - start clears err_cnt and err_flag.
- Without the macro: none of these ports or storage exist, and no comparison is made.

Decomposition:
- Package adc_stim_pkg holds:
  - the state enum (IDLE, SETTLE, WAIT_ACK, DONE);
  - the entry struct typedef (actual, signal, and expect under the macro);
  - default parameter constants.
- One sub-module is natural: adc_stim_table, the register-file table with write port and one async read port.

Test Plan:
- Load table {1/1, 6/2, 6/1, 4/1}, settle=2, loop_en=0, start, ack 4× → outputs step 1/1, 6/2, 6/1, 4/1; status_out 0..3; done=1 after 4th ack; stim_valid=0; 4/1 held.
- Ack pulse during SETTLE (settle=5) → ignored; index unchanged; the next ack in WAIT_ACK advances to 1.
- loop_en=1, 9 acks with DEPTH=4 → status_out ends at 1, loop_cnt=2, done never set.
- abort while in WAIT_ACK at index 2, with start in the same cycle → IDLE, outputs 0; a following start restarts at entry 0.
- Write attempts:
  - wr_en in SETTLE → table unchanged.
  - wr_addr=DEPTH in IDLE → ignored.
  - Write 0x00AA/0x0055 to entry 0 in the start cycle → first output 0x00AA/0x0055.
- With ADC_STIM_CHECK_EN: expected {1,2,3,4}, dut_result {1,2,9,4} on acks → err_cnt=1, err_flag=1; the next start clears both.

Source files
------------

// File: rtl/adc_stim_pkg.sv
// Shared types and default sizes for the ADC stimulus sequencer.
// ADC_STIM_CHECK_EN adds an expected-result field to each table entry.
package adc_stim_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_DEPTH    = 4;
  localparam int unsigned DEF_SETTLE_W = 8;
  localparam int unsigned DEF_LOOP_W   = 8;
  localparam int unsigned ERR_W        = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    WAIT_ACK,
    DONE
  } state_t;

  // One table row: the vector pair applied to the converter under test.
  typedef struct packed {
`ifdef ADC_STIM_CHECK_EN
    logic [DEF_DATA_W-1:0] exp_val;
`endif
    logic [DEF_DATA_W-1:0] actual;
    logic [DEF_DATA_W-1:0] signal;
  } entry_t;

endpackage

// File: rtl/adc_stim_sequencer_if.sv
// Control, table-write and stimulus-output bundle of the sequencer.
// ADC_STIM_CHECK_EN adds the result-checking signals.
interface adc_stim_sequencer_if #(
  parameter int unsigned DATA_W   = adc_stim_pkg::DEF_DATA_W,
  parameter int unsigned IDX_W    = $clog2(adc_stim_pkg::DEF_DEPTH),
  parameter int unsigned SETTLE_W = adc_stim_pkg::DEF_SETTLE_W,
  parameter int unsigned LOOP_W   = adc_stim_pkg::DEF_LOOP_W
);

  logic                start;
  logic                abort;
  logic                loop_en;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                status_in;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [DATA_W-1:0]   wr_actual;
  logic [DATA_W-1:0]   wr_signal;
  logic [DATA_W-1:0]   v_actual;
  logic [DATA_W-1:0]   v_signal;
  logic                stim_valid;
  logic [IDX_W-1:0]    status_out;
  logic                done;
  logic [LOOP_W-1:0]   loop_cnt;
`ifdef ADC_STIM_CHECK_EN
  logic [DATA_W-1:0]              dut_result;
  logic [DATA_W-1:0]              wr_expect;
  logic [adc_stim_pkg::ERR_W-1:0] err_cnt;
  logic                           err_flag;
`endif

  modport master (
`ifdef ADC_STIM_CHECK_EN
    output dut_result, wr_expect,
    input  err_cnt, err_flag,
`endif
    output start, abort, loop_en, settle_cycles, status_in,
    output wr_en, wr_addr, wr_actual, wr_signal,
    input  v_actual, v_signal, stim_valid, status_out, done, loop_cnt
  );

  modport slave (
`ifdef ADC_STIM_CHECK_EN
    input  dut_result, wr_expect,
    output err_cnt, err_flag,
`endif
    input  start, abort, loop_en, settle_cycles, status_in,
    input  wr_en, wr_addr, wr_actual, wr_signal,
    output v_actual, v_signal, stim_valid, status_out, done, loop_cnt
  );

endinterface

// File: rtl/adc_stim_table.sv
// Register-file vector table: one write port, one async read port with
// write-first forwarding so a row written in the start cycle is seen by the load.
module adc_stim_table
  import adc_stim_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  entry_t           wdata,
  input  logic [IDX_W-1:0] raddr,
  output entry_t           rdata_c
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/adc_stim_sequencer.sv
// Steps a programmable vector table into the DUT, one entry per acknowledge edge
// after a settle delay; one-shot or looping. ADC_STIM_CHECK_EN adds result checking.
module adc_stim_sequencer
  import adc_stim_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned IDX_W    = $clog2(DEPTH),
  parameter int unsigned SETTLE_W = DEF_SETTLE_W,
  parameter int unsigned LOOP_W   = DEF_LOOP_W
) (
  input logic               clk,
  input logic               rst_n,
  adc_stim_sequencer_if.slave bus
);

  state_t              state;
  logic                prev_status;
  logic [IDX_W-1:0]    idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [DATA_W-1:0]   v_actual_q;
  logic [DATA_W-1:0]   v_signal_q;
  logic                stim_valid_q;
  logic                done_q;
  logic [LOOP_W-1:0]   loop_cnt_q;
`ifdef ADC_STIM_CHECK_EN
  logic [DATA_W-1:0]   exp_q;
  logic [ERR_W-1:0]    err_cnt_q;
  logic                err_flag_q;
`endif

  logic             idle_like_c;
  logic             ack_c;
  logic             at_last_c;
  logic             wr_ok_c;
  logic             load_c;
  logic [IDX_W-1:0] rd_addr_c;
  entry_t           wr_entry_c;
  entry_t           rd_entry_c;

  assign idle_like_c = (state == IDLE) || (state == DONE);
  assign ack_c       = bus.status_in & ~prev_status;
  assign at_last_c   = (idx == IDX_W'(DEPTH - 1));
  assign wr_ok_c     = bus.wr_en && idle_like_c && (32'(bus.wr_addr) < DEPTH);

  // The only read is the next entry to load: row 0 on start or wrap, else idx+1.
  assign rd_addr_c = (idle_like_c || at_last_c) ? '0 : idx + IDX_W'(1);

  assign load_c = !bus.abort &&
                  ((idle_like_c && bus.start) ||
                   ((state == WAIT_ACK) && ack_c && (!at_last_c || bus.loop_en)));

  always_comb begin
    wr_entry_c        = '0;
    wr_entry_c.actual = DEF_DATA_W'(bus.wr_actual);
    wr_entry_c.signal = DEF_DATA_W'(bus.wr_signal);
`ifdef ADC_STIM_CHECK_EN
    wr_entry_c.exp_val = DEF_DATA_W'(bus.wr_expect);
`endif
  end

  adc_stim_table #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_ok_c),
    .waddr   (bus.wr_addr),
    .wdata   (wr_entry_c),
    .raddr   (rd_addr_c),
    .rdata_c (rd_entry_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prev_status  <= 1'b0;
      idx          <= '0;
      settle_cnt   <= '0;
      v_actual_q   <= '0;
      v_signal_q   <= '0;
      stim_valid_q <= 1'b0;
      done_q       <= 1'b0;
      loop_cnt_q   <= '0;
`ifdef ADC_STIM_CHECK_EN
      exp_q        <= '0;
      err_cnt_q    <= '0;
      err_flag_q   <= 1'b0;
`endif
    end else begin
      prev_status <= bus.status_in;
      if (bus.abort) begin
        // Abort wins over start and ack; the pass count survives it.
        state        <= IDLE;
        idx          <= '0;
        v_actual_q   <= '0;
        v_signal_q   <= '0;
        stim_valid_q <= 1'b0;
        done_q       <= 1'b0;
      end else begin
        if (load_c) begin
          state        <= SETTLE;
          idx          <= rd_addr_c;
          settle_cnt   <= bus.settle_cycles;
          v_actual_q   <= DATA_W'(rd_entry_c.actual);
          v_signal_q   <= DATA_W'(rd_entry_c.signal);
          stim_valid_q <= 1'b1;
`ifdef ADC_STIM_CHECK_EN
          exp_q        <= DATA_W'(rd_entry_c.exp_val);
`endif
        end
        case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              loop_cnt_q <= '0;
              done_q     <= 1'b0;
`ifdef ADC_STIM_CHECK_EN
              err_cnt_q  <= '0;
              err_flag_q <= 1'b0;
`endif
            end
          end
          SETTLE: begin
            if (settle_cnt == '0) state <= WAIT_ACK;
            else settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
          WAIT_ACK: begin
            if (ack_c) begin
`ifdef ADC_STIM_CHECK_EN
              if (bus.dut_result != exp_q) begin
                err_flag_q <= 1'b1;
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
              end
`endif
              if (at_last_c && bus.loop_en && (loop_cnt_q != '1))
                loop_cnt_q <= loop_cnt_q + LOOP_W'(1);
              if (at_last_c && !bus.loop_en) begin
                state        <= DONE;
                done_q       <= 1'b1;
                stim_valid_q <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.v_actual   = v_actual_q;
  assign bus.v_signal   = v_signal_q;
  assign bus.stim_valid = stim_valid_q;
  assign bus.status_out = idx;
  assign bus.done       = done_q;
  assign bus.loop_cnt   = loop_cnt_q;
`ifdef ADC_STIM_CHECK_EN
  assign bus.err_cnt    = err_cnt_q;
  assign bus.err_flag   = err_flag_q;
`endif

endmodule

// File: tb/tb_adc_stim_sequencer.sv
// Directed + randomized bench for adc_stim_sequencer against a cycle-level
// reference model of the table walk; a DEPTH=3 instance covers out-of-range writes.
module tb_adc_stim_sequencer;
  import adc_stim_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  adc_stim_sequencer_if #(.DATA_W(16), .IDX_W(2), .SETTLE_W(8), .LOOP_W(8)) bus ();
  adc_stim_sequencer_if #(.DATA_W(16), .IDX_W(2), .SETTLE_W(8), .LOOP_W(8)) bus3 ();

  adc_stim_sequencer #(.DATA_W(16), .DEPTH(4), .IDX_W(2), .SETTLE_W(8), .LOOP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  adc_stim_sequencer #(.DATA_W(16), .DEPTH(3), .IDX_W(2), .SETTLE_W(8), .LOOP_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: table contents, current position, and the first edge
  // at which an acknowledge may be taken for the vector now applied.
  int unsigned m_a [DEPTH];
  int unsigned m_s [DEPTH];
  int unsigned m_pos, m_va, m_vs, m_loop, m_ready, m_cyc;
  bit          m_run, m_done, m_valid, m_prev;
`ifdef ADC_STIM_CHECK_EN
  int unsigned m_e [DEPTH];
  int unsigned m_errc;
  bit          m_flag;
  int unsigned res_plan [4] = '{1, 2, 9, 4};
`endif

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_a[i] = 0;
      m_s[i] = 0;
`ifdef ADC_STIM_CHECK_EN
      m_e[i] = 0;
`endif
    end
    m_pos = 0; m_va = 0; m_vs = 0; m_loop = 0; m_ready = 0;
    m_run = 0; m_done = 0; m_valid = 0; m_prev = 0;
`ifdef ADC_STIM_CHECK_EN
    m_errc = 0;
    m_flag = 0;
`endif
  endtask

  task automatic model_load(input int unsigned p);
    m_pos   = p;
    m_va    = m_a[p];
    m_vs    = m_s[p];
    m_valid = 1;
    m_run   = 1;
    m_ready = m_cyc + 32'(bus.settle_cycles) + 2;
  endtask

  task automatic model_edge();
    bit ack;
    m_cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ack    = bus.status_in && !m_prev;
    m_prev = bus.status_in;
    if (bus.wr_en && !m_run) begin
      m_a[bus.wr_addr] = 32'(bus.wr_actual);
      m_s[bus.wr_addr] = 32'(bus.wr_signal);
`ifdef ADC_STIM_CHECK_EN
      m_e[bus.wr_addr] = 32'(bus.wr_expect);
`endif
    end
    if (bus.abort) begin
      m_run = 0; m_done = 0; m_valid = 0; m_va = 0; m_vs = 0; m_pos = 0;
    end else if (!m_run) begin
      if (bus.start) begin
        m_loop = 0;
        m_done = 0;
`ifdef ADC_STIM_CHECK_EN
        m_errc = 0;
        m_flag = 0;
`endif
        model_load(0);
      end
    end else if (ack && m_cyc >= m_ready) begin
`ifdef ADC_STIM_CHECK_EN
      if (32'(bus.dut_result) != m_e[m_pos]) begin
        m_flag = 1;
        if (m_errc < 16'hFFFF) m_errc++;
      end
`endif
      if (m_pos < DEPTH - 1) model_load(m_pos + 1);
      else if (bus.loop_en) begin
        if (m_loop < 255) m_loop++;
        model_load(0);
      end else begin
        m_run = 0; m_done = 1; m_valid = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/v_actual"},   32'(bus.v_actual),   m_va);
    check({tag, "/v_signal"},   32'(bus.v_signal),   m_vs);
    check({tag, "/stim_valid"}, 32'(bus.stim_valid), 32'(m_valid));
    check({tag, "/status_out"}, 32'(bus.status_out), m_pos);
    check({tag, "/done"},       32'(bus.done),       32'(m_done));
    check({tag, "/loop_cnt"},   32'(bus.loop_cnt),   m_loop);
`ifdef ADC_STIM_CHECK_EN
    check({tag, "/err_cnt"},    32'(bus.err_cnt),    m_errc);
    check({tag, "/err_flag"},   32'(bus.err_flag),   32'(m_flag));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all($sformatf("cyc%0d", m_cyc));
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!(m_run && (m_cyc + 1 >= m_ready)) && guard < 64) begin
      step();
      guard++;
    end
    check("wait_ready_timeout", 32'(guard < 64), 32'd1);
  endtask

  task automatic ack_pulse();
    wait_ready();
    bus.status_in = 1'b1;
    step();
    bus.status_in = 1'b0;
    step();
  endtask

  task automatic wr(input int unsigned addr, input int unsigned a, input int unsigned s,
                    input int unsigned e);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 2'(addr);
    bus.wr_actual = 16'(a);
    bus.wr_signal = 16'(s);
`ifdef ADC_STIM_CHECK_EN
    bus.wr_expect = 16'(e);
`else
    if (e != 0) bus.wr_signal = 16'(s);
`endif
    step();
  endtask

  int unsigned a3 [3];
  int unsigned pa [4] = '{1, 6, 6, 4};
  int unsigned ps [4] = '{1, 2, 1, 1};

  initial begin
    {bus.start, bus.abort, bus.loop_en, bus.status_in, bus.wr_en} = '0;
    bus.settle_cycles = '0; bus.wr_addr = '0; bus.wr_actual = '0; bus.wr_signal = '0;
    {bus3.start, bus3.abort, bus3.loop_en, bus3.status_in, bus3.wr_en} = '0;
    bus3.settle_cycles = '0; bus3.wr_addr = '0; bus3.wr_actual = '0; bus3.wr_signal = '0;
`ifdef ADC_STIM_CHECK_EN
    bus.dut_result = '0; bus.wr_expect = '0; bus3.dut_result = '0; bus3.wr_expect = '0;
`endif
    m_cyc = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // One-shot walk through {1/1, 6/2, 6/1, 4/1}, expected {1,2,3,4}.
    for (int i = 0; i < 4; i++) wr(i, pa[i], ps[i], i + 1);
    bus.settle_cycles = 8'd2;
    bus.loop_en = 1'b0;
    bus.start = 1'b1;
    step();
    check("first_vec_actual", 32'(bus.v_actual), 32'd1);
    for (int i = 0; i < 4; i++) begin
`ifdef ADC_STIM_CHECK_EN
      bus.dut_result = 16'(res_plan[i]);
`endif
      ack_pulse();
    end
    check("oneshot_done", 32'(bus.done), 32'd1);
    check("oneshot_valid", 32'(bus.stim_valid), 32'd0);
    check("oneshot_hold", {bus.v_actual, bus.v_signal}, 32'h0004_0001);
    check("oneshot_idx", 32'(bus.status_out), 32'd3);
`ifdef ADC_STIM_CHECK_EN
    check("err_cnt_one", 32'(bus.err_cnt), 32'd1);
    check("err_flag_set", 32'(bus.err_flag), 32'd1);
`endif

    // Early ack during settle is dropped; the next one advances.
    bus.settle_cycles = 8'd5;
    bus.start = 1'b1;
    step();
    repeat (2) step();
    bus.status_in = 1'b1;
    step();
    bus.status_in = 1'b0;
    step();
    check("settle_ack_ignored", 32'(bus.status_out), 32'd0);
    ack_pulse();
    check("ack_after_settle", 32'(bus.status_out), 32'd1);

    // Abort beats start and ack in the same cycle at index 2.
    ack_pulse();
    wait_ready();
    bus.abort = 1'b1; bus.start = 1'b1; bus.status_in = 1'b1;
    step();
    bus.status_in = 1'b0;
    check("abort_valid", 32'(bus.stim_valid), 32'd0);
    check("abort_idx", 32'(bus.status_out), 32'd0);
    step();
    bus.start = 1'b1;
    step();
    check("restart_entry0", {bus.v_actual, bus.v_signal}, 32'h0001_0001);

    // Table writes while sequencing must not land.
    bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_actual = 16'hBAD1; bus.wr_signal = 16'hBAD2;
    step();
    ack_pulse();
    check("settle_write_ignored", {bus.v_actual, bus.v_signal}, 32'h0006_0002);

    // Loop mode: nine acks end on index 1 after two passes.
    bus.abort = 1'b1;
    step();
    bus.loop_en = 1'b1;
    bus.settle_cycles = 8'd1;
    bus.start = 1'b1;
    step();
    repeat (9) ack_pulse();
    check("loop_idx", 32'(bus.status_out), 32'd1);
    check("loop_cnt2", 32'(bus.loop_cnt), 32'd2);
    check("loop_no_done", 32'(bus.done), 32'd0);

    // Pass counter saturates at all-ones and survives abort.
    bus.settle_cycles = 8'd0;
    repeat (1030) ack_pulse();
    check("loop_sat", 32'(bus.loop_cnt), 32'd255);
    bus.abort = 1'b1;
    step();
    check("loop_held_abort", 32'(bus.loop_cnt), 32'd255);

    // Write in the start cycle is forwarded to the first load.
    bus.loop_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_actual = 16'h00AA; bus.wr_signal = 16'h0055;
    bus.start = 1'b1;
    step();
    check("start_write_first", {bus.v_actual, bus.v_signal}, 32'h00AA_0055);

    // DEPTH=3 instance: address 3 is out of range and must be ignored.
    for (int i = 0; i < 3; i++) a3[i] = $urandom_range(1, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      bus3.wr_en = 1'b1; bus3.wr_addr = 2'(i);
      bus3.wr_actual = 16'(a3[i]); bus3.wr_signal = 16'(a3[i] ^ 32'h5A5A);
      step();
    end
    bus3.wr_addr = 2'd3; bus3.wr_actual = 16'hDEAD; bus3.wr_signal = 16'hBEEF;
    step();
    bus3.wr_en = 1'b0;
    bus3.start = 1'b1;
    step();
    bus3.start = 1'b0;
    check("d3_entry0", 32'(bus3.v_actual), a3[0]);
    for (int i = 1; i <= 3; i++) begin
      step();
      bus3.status_in = 1'b1;
      step();
      bus3.status_in = 1'b0;
      if (i < 3) begin
        check("d3_actual", 32'(bus3.v_actual), a3[i]);
        check("d3_signal", 32'(bus3.v_signal), a3[i] ^ 32'h5A5A);
        check("d3_idx", 32'(bus3.status_out), 32'(i));
      end
    end
    check("d3_done", 32'(bus3.done), 32'd1);
    check("d3_hold_idx", 32'(bus3.status_out), 32'd2);
    check("d3_hold_actual", 32'(bus3.v_actual), a3[2]);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bus.status_in     = 1'($urandom_range(0, 1));
      bus.start         = ($urandom_range(0, 19) == 0);
      bus.abort         = ($urandom_range(0, 59) == 0);
      bus.loop_en       = 1'($urandom_range(0, 1));
      bus.settle_cycles = 8'($urandom_range(0, 3));
      bus.wr_en         = ($urandom_range(0, 7) == 0);
      bus.wr_addr       = 2'($urandom_range(0, 3));
      bus.wr_actual     = 16'($urandom);
      bus.wr_signal     = 16'($urandom);
`ifdef ADC_STIM_CHECK_EN
      bus.wr_expect     = 16'($urandom_range(0, 3));
      bus.dut_result    = 16'($urandom_range(0, 3));
`endif
      step();
    end
    bus.status_in = 1'b0;

    // Asynchronous reset mid-sequence clears state and table.
    bus.settle_cycles = 8'd3;
    bus.start = 1'b1;
    step();
    step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    step();
    step();
    rst_n = 1'b1;
    bus.start = 1'b1;
    step();
    check("post_rst_table_zero", {bus.v_actual, bus.v_signal}, 32'h0);
    check("post_rst_valid", 32'(bus.stim_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
